sample_mac_pipe: RTL and testbench

SAMPLE_MAC_PIPE -- requirements
Module: sample_mac_pipe

---
 rtl/sample_mac_pipe_pkg.sv | 30 +++
 rtl/sample_mac_pipe_mul.sv | 35 +++
 rtl/sample_mac_pipe.sv | 89 ++++++++
 tb/tb_sample_mac_pipe.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/sample_mac_pipe_pkg.sv
// Shared constants and signed-resize helpers for the sample_mac_pipe MAC block.
package sample_mac_pipe_pkg;

  localparam int SAT_WRAP      = 0;
  localparam int SAT_CLAMP     = 1;
  localparam int NUM_STAGE_MIN = 3;
  localparam int NUM_STAGE_MAX = 8;
  localparam int RESIZE_W      = 64;

  function automatic logic signed [RESIZE_W-1:0] sat_hi(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [RESIZE_W-1:0] sat_lo(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  function automatic logic fits(input logic signed [RESIZE_W-1:0] v, input int w);
    return (v <= sat_hi(w)) && (v >= sat_lo(w));
  endfunction

  // Clamp a wide signed value into the w-bit signed range (result still 64 bits wide).
  function automatic logic signed [RESIZE_W-1:0] sat_resize(input logic signed [RESIZE_W-1:0] v,
                                                            input int w);
    if (v > sat_hi(w))      return sat_hi(w);
    else if (v < sat_lo(w)) return sat_lo(w);
    else                    return v;
  endfunction

endpackage

// File: rtl/sample_mac_pipe_mul.sv
// Signed multiply pipeline: one input register stage, then NUM_STAGE-2 product registers.
module sample_mac_pipe_mul
  import sample_mac_pipe_pkg::*;
#(
  parameter int A_WIDTH   = 14,
  parameter int B_WIDTH   = 14,
  parameter int NUM_STAGE = 3
) (
  input  logic                              clk,
  input  logic                              ce,
  input  logic signed [A_WIDTH-1:0]         a,
  input  logic signed [B_WIDTH-1:0]         b,
  output logic signed [A_WIDTH+B_WIDTH-1:0] p
);

  localparam int PW   = A_WIDTH + B_WIDTH;
  localparam int PSTG = NUM_STAGE - 2;

  logic signed [A_WIDTH-1:0] a_p0;
  logic signed [B_WIDTH-1:0] b_p0;
  logic signed [PW-1:0]      prod_p [PSTG];

  // p0: operand registers; p1..: full-width product, then delay-only registers
  always_ff @(posedge clk) begin
    if (ce) begin
      a_p0      <= a;
      b_p0      <= b;
      prod_p[0] <= PW'(a_p0) * PW'(b_p0);
      for (int i = 1; i < PSTG; i++) prod_p[i] <= prod_p[i-1];
    end
  end

  assign p = prod_p[PSTG-1];

endmodule

// File: rtl/sample_mac_pipe.sv
// Pipelined signed multiply-accumulate with saturating or wrapping output formatting.
module sample_mac_pipe
  import sample_mac_pipe_pkg::*;
#(
  parameter int A_WIDTH   = 14,
  parameter int B_WIDTH   = 14,
  parameter int P_WIDTH   = 14,
  parameter int NUM_STAGE = 3,
  parameter int GUARD     = 8,
  parameter int SAT_MODE  = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce,
  input  logic                      in_valid,
  input  logic signed [A_WIDTH-1:0] din0,
  input  logic signed [B_WIDTH-1:0] din1,
  input  logic                      acc_en,
  input  logic                      acc_clr,
  output logic                      out_valid,
  output logic signed [P_WIDTH-1:0] dout,
  output logic                      ovf
);

  localparam int PW        = A_WIDTH + B_WIDTH;
  localparam int ACC_WIDTH = PW + GUARD;
  localparam int L         = NUM_STAGE - 2;

  if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_stage
    $error("sample_mac_pipe: NUM_STAGE out of range");
  end
  if (ACC_WIDTH > RESIZE_W) begin : g_bad_acc
    $error("sample_mac_pipe: accumulator wider than resize helper");
  end

  logic [NUM_STAGE-2:0]        vld_p, en_p, clr_p;
  logic signed [PW-1:0]        prod_p;
  logic signed [ACC_WIDTH-1:0] prod_ext, acc, acc_next;
  logic signed [P_WIDTH-1:0]   fmt;
  logic                        fmt_ovf, take, load, first_pend;

  sample_mac_pipe_mul #(
    .A_WIDTH  (A_WIDTH),
    .B_WIDTH  (B_WIDTH),
    .NUM_STAGE(NUM_STAGE)
  ) u_mul (
    .clk(clk),
    .ce (ce),
    .a  (din0),
    .b  (din1),
    .p  (prod_p)
  );

  // Final stage: the first beat after reset always starts a fresh accumulation.
  always_comb begin
    prod_ext = ACC_WIDTH'(prod_p);
    take     = vld_p[L];
    load     = first_pend | clr_p[L] | ~en_p[L];
    acc_next = load ? prod_ext : acc + prod_ext;
    fmt_ovf  = !fits(64'(acc_next), P_WIDTH);
    if (SAT_MODE == SAT_CLAMP) fmt = P_WIDTH'(sat_resize(64'(acc_next), P_WIDTH));
    else                       fmt = acc_next[P_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p      <= '0;
      en_p       <= '0;
      clr_p      <= '0;
      acc        <= '0;
      dout       <= '0;
      ovf        <= 1'b0;
      out_valid  <= 1'b0;
      first_pend <= 1'b1;
    end else if (ce) begin
      vld_p     <= {vld_p[NUM_STAGE-3:0], in_valid};
      en_p      <= {en_p[NUM_STAGE-3:0],  acc_en};
      clr_p     <= {clr_p[NUM_STAGE-3:0], acc_clr};
      out_valid <= take;
      if (take) begin
        acc        <= acc_next;
        dout       <= fmt;
        ovf        <= fmt_ovf;
        first_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sample_mac_pipe.sv
// Directed bench for sample_mac_pipe: saturating and wrapping instances share one stimulus.
module tb_sample_mac_pipe;

  logic               clk = 1'b0;
  logic               reset, ce, in_valid, acc_en, acc_clr;
  logic signed [13:0] din0, din1;
  logic               ov_s, ovf_s, ov_w, ovf_w;
  logic signed [13:0] dout_s, dout_w;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sample_mac_pipe #(.SAT_MODE(1)) dut_s (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
    .din0(din0), .din1(din1), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(ov_s), .dout(dout_s), .ovf(ovf_s)
  );

  sample_mac_pipe #(.SAT_MODE(0)) dut_w (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
    .din0(din0), .din1(din1), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(ov_w), .dout(dout_w), .ovf(ovf_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int a, input int b, input logic en, input logic clr);
    din0     = 14'(a);
    din1     = 14'(b);
    acc_en   = en;
    acc_clr  = clr;
    in_valid = 1'b1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ce = 1'b1; in_valid = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
    din0 = '0; din1 = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_out_valid", int'(ov_s), 0);
    chk("rst_dout", int'(dout_s), 0);
    chk("rst_ovf", int'(ovf_s), 0);

    // single product, latency 3
    drive(100, -50, 1'b0, 1'b1); tick(); idle();
    chk("lat_c1_valid", int'(ov_s), 0);
    tick();
    chk("lat_c2_valid", int'(ov_s), 0);
    tick();
    chk("lat_c3_valid", int'(ov_s), 1);
    chk("basic_dout", int'(dout_s), -5000);
    chk("basic_ovf", int'(ovf_s), 0);
    chk("basic_dout_wrap", int'(dout_w), -5000);
    tick();
    chk("hold_valid", int'(ov_s), 0);
    chk("hold_dout", int'(dout_s), -5000);

    // 127*127 = 16129 overflows 14-bit signed
    drive(127, 127, 1'b0, 1'b1); tick(); idle(); tick(); tick();
    chk("sat_dout", int'(dout_s), 8191);
    chk("sat_ovf", int'(ovf_s), 1);
    chk("wrap_dout", int'(dout_w), -255);
    chk("wrap_ovf", int'(ovf_w), 1);

    // most negative squared = 2^26
    drive(-8192, -8192, 1'b0, 1'b1); tick(); idle(); tick(); tick();
    chk("negsq_sat_dout", int'(dout_s), 8191);
    chk("negsq_sat_ovf", int'(ovf_s), 1);
    chk("negsq_wrap_dout", int'(dout_w), 0);
    chk("negsq_wrap_ovf", int'(ovf_w), 1);

    // back-to-back accumulation
    drive(10, 10, 1'b1, 1'b1); tick();
    drive(10, 10, 1'b1, 1'b0); tick();
    drive(10, 10, 1'b1, 1'b0); tick();
    chk("acc1_valid", int'(ov_s), 1);
    chk("acc1_dout", int'(dout_s), 100);
    drive(10, 10, 1'b1, 1'b0); tick();
    chk("acc2_valid", int'(ov_s), 1);
    chk("acc2_dout", int'(dout_s), 200);
    idle(); tick();
    chk("acc3_valid", int'(ov_s), 1);
    chk("acc3_dout", int'(dout_s), 300);
    tick();
    chk("acc4_valid", int'(ov_s), 1);
    chk("acc4_dout", int'(dout_s), 400);
    tick();
    chk("acc_end_valid", int'(ov_s), 0);

    // two-cycle ce stall after the second of three beats
    drive(5, 1, 1'b0, 1'b0); tick();
    drive(6, 1, 1'b0, 1'b0); tick();
    chk("stall_pre_valid", int'(ov_s), 0);
    drive(7, 1, 1'b0, 1'b0); ce = 1'b0; tick();
    chk("stall_c1_valid", int'(ov_s), 0);
    tick();
    chk("stall_c2_valid", int'(ov_s), 0);
    ce = 1'b1; tick(); idle();
    chk("stall_o1_valid", int'(ov_s), 1);
    chk("stall_o1_dout", int'(dout_s), 5);
    tick();
    chk("stall_o2_valid", int'(ov_s), 1);
    chk("stall_o2_dout", int'(dout_s), 6);
    tick();
    chk("stall_o3_valid", int'(ov_s), 1);
    chk("stall_o3_dout", int'(dout_s), 7);
    tick();
    chk("stall_end_valid", int'(ov_s), 0);

    // reset with two beats in flight
    drive(9, 9, 1'b0, 1'b1); tick();
    drive(8, 8, 1'b0, 1'b1); tick();
    idle(); reset = 1'b1; tick(); reset = 1'b0;
    chk("flush_valid0", int'(ov_s), 0);
    chk("flush_dout", int'(dout_s), 0);
    chk("flush_ovf", int'(ovf_s), 0);
    tick(); tick(); tick();
    chk("flush_valid3", int'(ov_s), 0);
    drive(3, 4, 1'b1, 1'b0); tick(); idle(); tick(); tick();
    chk("post_rst_valid", int'(ov_s), 1);
    chk("post_rst_dout", int'(dout_s), 12);

    // sideband on an invalid beat must not touch the accumulator
    din0 = 14'sd50; din1 = 14'sd50; acc_en = 1'b0; acc_clr = 1'b1; in_valid = 1'b0;
    tick();
    drive(1, 1, 1'b1, 1'b0); tick(); idle(); tick();
    chk("invalid_beat_valid", int'(ov_s), 0);
    tick();
    chk("invalid_acc_valid", int'(ov_s), 1);
    chk("invalid_acc_dout", int'(dout_s), 13);

    // clear wins over enable
    drive(2, 3, 1'b1, 1'b1); tick(); idle(); tick(); tick();
    chk("clr_wins_dout", int'(dout_s), 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
